// File: rtl/usr_mem_rd_streamer.sv
// Read-side sequencer for the usr_mem two-port SRAMs: walks an address range and streams words out.
// Optional feature macro: USR_MEM_RD_STRIDE_EN (programmable address stride; default stride is 1).
module usr_mem_rd_streamer #(
  parameter int AW   = 10,
  parameter int DW   = 16,
  parameter int LENW = 11
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            clr,
  input  logic [AW-1:0]   cfg_base,
  input  logic [LENW-1:0] cfg_len,
  input  logic [AW-1:0]   cfg_stride,
  output logic            mem_cena,
  output logic [AW-1:0]   mem_aa,
  input  logic [DW-1:0]   mem_qa,
  output logic            m_valid,
  input  logic            m_ready,
  output logic [DW-1:0]   m_data,
  output logic            m_last,
  output logic            busy,
  output logic            done
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [AW-1:0]       r_addr;
  logic [LENW-1:0]     r_remain;
  logic                r_infl;
  logic                r_infl_last;
  logic                r_done;
  logic [1:0][DW-1:0]  r_fifo_data;
  logic [1:0]          r_fifo_last;
  logic                r_wp;
  logic                r_rp;
  logic [1:0]          r_cnt;
  logic [1:0]          w_occ;
  logic [AW-1:0]       w_step;
  logic                w_start_ok;
  logic                w_pop;
  logic                w_pop_last;
  logic                w_credit;
  logic                w_issue;

  assign w_start_ok = (r_state == S_IDLE) & start & ~clr;
  assign w_pop      = m_valid & m_ready;
  assign w_pop_last = w_pop & r_fifo_last[r_rp];
  // A word popped this cycle frees its slot in time for a read issued this cycle.
  assign w_occ      = r_cnt - {1'b0, w_pop} + {1'b0, r_infl};
  assign w_credit   = (w_occ < 2'd2);

  always_comb begin
    w_state_nxt = r_state;
    w_issue     = 1'b0;
    case (r_state)
      S_IDLE:  if (start && cfg_len != '0) w_state_nxt = S_RUN;
      S_RUN: begin
        w_issue = w_credit;
        if (w_credit && r_remain == LENW'(1)) w_state_nxt = S_DRAIN;
      end
      S_DRAIN: if (w_pop_last) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
    if (clr) begin
      w_state_nxt = S_IDLE;
      w_issue     = 1'b0;
    end
  end

`ifdef USR_MEM_RD_STRIDE_EN
  logic [AW-1:0] r_stride;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          r_stride <= '0;
    else if (w_start_ok) r_stride <= cfg_stride;
  end

  assign w_step = r_stride;
`else
  logic w_unused_stride;

  assign w_unused_stride = ^cfg_stride;
  assign w_step          = AW'(1);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_addr      <= '0;
      r_remain    <= '0;
      r_infl      <= 1'b0;
      r_infl_last <= 1'b0;
      r_done      <= 1'b0;
      r_wp        <= 1'b0;
      r_rp        <= 1'b0;
      r_cnt       <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_done      <= ~clr & ((r_state == S_IDLE && start && cfg_len == '0) | w_pop_last);
      r_infl      <= w_issue;
      r_infl_last <= w_issue & (r_remain == LENW'(1));
      if (w_start_ok) begin
        r_addr   <= cfg_base;
        r_remain <= cfg_len;
      end else if (w_issue) begin
        r_addr   <= r_addr + w_step;
        r_remain <= r_remain - LENW'(1);
      end
      // clr drops buffered words and the read still in flight.
      if (clr) begin
        r_wp  <= 1'b0;
        r_rp  <= 1'b0;
        r_cnt <= '0;
      end else begin
        if (r_infl) r_wp <= ~r_wp;
        if (w_pop)  r_rp <= ~r_rp;
        r_cnt <= r_cnt + {1'b0, r_infl} - {1'b0, w_pop};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fifo_data <= '0;
      r_fifo_last <= '0;
    end else if (r_infl && !clr) begin
      r_fifo_data[r_wp] <= mem_qa;
      r_fifo_last[r_wp] <= r_infl_last;
    end
  end

  assign mem_cena = ~w_issue;
  assign mem_aa   = r_addr;
  assign m_valid  = (r_cnt != 2'd0);
  assign m_data   = r_fifo_data[r_rp];
  assign m_last   = m_valid & r_fifo_last[r_rp];
  assign busy     = (r_state != S_IDLE);
  assign done     = r_done;

endmodule

// File: tb/tb_usr_mem_rd_streamer.sv
// Randomized bench for usr_mem_rd_streamer: SRAM model, ready driver, monitor and transfer-level reference.
module tb_usr_mem_rd_streamer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        clr;
  logic [9:0]  cfg_base;
  logic [10:0] cfg_len;
  logic [9:0]  cfg_stride;
  logic        mem_cena;
  logic [9:0]  mem_aa;
  logic [15:0] mem_qa = 16'h0;
  logic        m_valid;
  logic        m_ready;
  logic [15:0] m_data;
  logic        m_last;
  logic        busy;
  logic        done;

  usr_mem_rd_streamer #(.AW(10), .DW(16), .LENW(11)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .clr(clr),
    .cfg_base(cfg_base), .cfg_len(cfg_len), .cfg_stride(cfg_stride),
    .mem_cena(mem_cena), .mem_aa(mem_aa), .mem_qa(mem_qa),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [15:0] sram [1024];
  always @(posedge clk) if (!mem_cena) mem_qa <= sram[mem_aa];

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  // ready pattern: 0 = always 1, 1 = 1,0,0 repeating, 2 = random
  int rdy_mode = 0;
  int rdy_ph   = 0;
  initial begin
    m_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0: m_ready = 1'b1;
        1: begin m_ready = (rdy_ph == 0); rdy_ph = (rdy_ph + 1) % 3; end
        default: m_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  logic [9:0]  aq[$];
  logic [15:0] dq[$];
  bit          lq[$];
  int          hq[$];
  int          issued, popped, n_done, first_iss, done_cyc;
  bit          saw_busy, stalled;
  logic [15:0] prev_d;
  logic        prev_l;

  task automatic clear_mon();
    aq.delete(); dq.delete(); lq.delete(); hq.delete();
    issued = 0; popped = 0; n_done = 0; first_iss = -1; done_cyc = -1; saw_busy = 0;
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      stalled = 1'b0;
    end else begin
      if (!mem_cena) begin
        aq.push_back(mem_aa);
        if (first_iss < 0) first_iss = cyc;
        issued++;
      end
      if (m_valid && m_ready) begin
        dq.push_back(m_data); lq.push_back(m_last); hq.push_back(cyc); popped++;
      end
      if (done) begin n_done++; done_cyc = cyc; end
      if (busy) saw_busy = 1'b1;
      if (!mem_cena) chk("credit_outstanding_le2", 32'(issued - popped <= 2), 1);
      if (stalled) begin
        chk("stall_hold_valid", m_valid, 1);
        chk("stall_hold_data", m_data, prev_d);
        chk("stall_hold_last", m_last, prev_l);
      end
      stalled = m_valid && !m_ready && !clr;
      prev_d  = m_data;
      prev_l  = m_last;
    end
  end

  task automatic run_xfer(input string nm, input logic [9:0] base, input logic [10:0] len,
                          input logic [9:0] stride, input int mode, input bit dup);
    int sc, budget, step, a;
    clear_mon();
    rdy_mode = mode;
    @(posedge clk); #1;
    cfg_base = base; cfg_len = len; cfg_stride = stride; start = 1'b1; sc = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    cfg_base = 10'($urandom); cfg_len = 11'($urandom); cfg_stride = 10'($urandom);
    if (dup) begin
      start = 1'b1; cfg_len = 11'd5;
      @(posedge clk); #1;
      start = 1'b0;
    end
    budget = 20 * int'(len) + 40;
    while (n_done == 0 && budget > 0) begin @(posedge clk); budget--; end
    repeat (3) @(posedge clk);
    #1;
`ifdef USR_MEM_RD_STRIDE_EN
    step = int'(stride);
`else
    step = 1;
`endif
    chk({nm, "_done_count"}, n_done, 1);
    chk({nm, "_read_count"}, aq.size(), 32'(len));
    chk({nm, "_word_count"}, dq.size(), 32'(len));
    for (int i = 0; i < int'(len); i++) begin
      a = (int'(base) + i * step) % 1024;
      if (i < aq.size()) chk({nm, "_addr"}, aq[i], a);
      if (i < dq.size()) begin
        chk({nm, "_data"}, dq[i], sram[a]);
        chk({nm, "_last"}, lq[i], (i == int'(len) - 1));
      end
    end
    if (len == 0) begin
      chk({nm, "_done_lat"}, done_cyc, sc + 1);
      chk({nm, "_busy_seen"}, saw_busy, 0);
    end else begin
      chk({nm, "_first_read_lat"}, first_iss, sc + 1);
      if (hq.size() > 0) begin
        chk({nm, "_valid_ge2"}, 32'(hq[0] - sc >= 2), 1);
        chk({nm, "_done_after_last"}, done_cyc, hq[hq.size() - 1] + 1);
        if (mode == 0) chk({nm, "_back_to_back"}, hq[hq.size() - 1] - hq[0], int'(len) - 1);
      end
    end
    chk({nm, "_idle_after"}, busy, 0);
  endtask

  task automatic chk_reset_outs(input string nm);
    chk({nm, "_cena"}, mem_cena, 1);
    chk({nm, "_aa"}, mem_aa, 0);
    chk({nm, "_valid"}, m_valid, 0);
    chk({nm, "_data"}, m_data, 0);
    chk({nm, "_last"}, m_last, 0);
    chk({nm, "_busy"}, busy, 0);
    chk({nm, "_done"}, done, 0);
  endtask

  initial begin
    int budget;
    for (int i = 0; i < 1024; i++) sram[i] = 16'(16'hA000 + i);
    rst_n = 1'b0; start = 1'b0; clr = 1'b0;
    cfg_base = '0; cfg_len = '0; cfg_stride = 10'd1;
    clear_mon();
    #2;
    chk_reset_outs("rst");
    repeat (3) @(posedge clk);
    #1; rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("idle_cena", mem_cena, 1);
    chk("idle_valid", m_valid, 0);
    chk("idle_busy", busy, 0);
    chk("idle_done", done, 0);

    run_xfer("basic", 10'h000, 11'd4, 10'd1, 0, 1'b0);
    run_xfer("toggle", 10'h000, 11'd4, 10'd1, 1, 1'b0);
    run_xfer("toggle_long", 10'h040, 11'd9, 10'd1, 1, 1'b0);
    run_xfer("wrap", 10'h3FE, 11'd4, 10'd1, 0, 1'b0);
    run_xfer("zero_len", 10'h123, 11'd0, 10'd1, 0, 1'b0);
    run_xfer("dup_start", 10'h080, 11'd4, 10'd1, 0, 1'b1);

    // abort after two words
    clear_mon();
    rdy_mode = 0;
    @(posedge clk); #1;
    cfg_base = 10'h020; cfg_len = 11'd8; cfg_stride = 10'd1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    budget = 40;
    while (popped < 2 && budget > 0) begin @(posedge clk); budget--; end
    chk("clr_reached_two", 32'(popped >= 2), 1);
    #1; clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    chk("clr_valid", m_valid, 0);
    chk("clr_busy", busy, 0);
    chk("clr_cena", mem_cena, 1);
    repeat (6) @(posedge clk);
    #1;
    chk("clr_no_done", n_done, 0);
    chk("clr_stays_idle", m_valid, 0);
    run_xfer("after_clr", 10'h010, 11'd2, 10'd1, 0, 1'b0);

    run_xfer("stride3", 10'h000, 11'd3, 10'd3, 0, 1'b0);

    for (int i = 0; i < 1024; i++) sram[i] = 16'($urandom);
    for (int t = 0; t < 8; t++)
      run_xfer("rand", 10'($urandom), 11'($urandom_range(1, 12)), 10'($urandom_range(0, 7)),
               (t % 2 == 0) ? 2 : 1, 1'b0);

    // asynchronous reset in the middle of a transfer
    clear_mon();
    rdy_mode = 1;
    @(posedge clk); #1;
    cfg_base = 10'h100; cfg_len = 11'd8; cfg_stride = 10'd1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #3; rst_n = 1'b0;
    #1;
    chk_reset_outs("async_rst");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_busy", busy, 0);
    run_xfer("post_rst", 10'h200, 11'd5, 10'd1, 2, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
